// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one step per clock, operands and result exchanged over valid/ready.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for operands, in_ready high
// S_CALC | WIDTH radix-2 iterations in progress
// S_DONE | result registered, out_valid high until consumer takes it
module muldiv_unit #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t state_q, state_d;

  logic [2:0]       op_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] db_q;
  logic             neg_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] result_q;

  // ---------------------------------------------------------------------------
  // Operand preparation at acceptance
  // ---------------------------------------------------------------------------
  logic             a_signed, b_signed;
  logic             sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             div_zero, div_ovf, special;
  logic [WIDTH-1:0] special_res;
  logic             neg_in;

  always_comb begin
    a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    sa       = a_signed & a[WIDTH-1];
    sb       = b_signed & b[WIDTH-1];
    mag_a    = sa ? -a : a;
    mag_b    = sb ? -b : b;
    // quotient and product follow sa^sb, a remainder takes the dividend's sign
    neg_in   = (op[2] && op[1]) ? sa : (sa ^ sb);
    div_zero = op[2] && (b == '0);
    div_ovf  = op[2] && !op[0] && (a == MOST_NEG) && (b == '1);
    special  = div_zero || div_ovf;
    if (div_zero) begin
      special_res = op[1] ? a : '1;
    end else begin
      special_res = op[1] ? '0 : MOST_NEG;
    end
  end

  // ---------------------------------------------------------------------------
  // One radix-2 step; hi/lo hold {partial product, multiplier} or
  // {partial remainder, dividend/quotient} depending on the op class.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_n, mul_lo_n;
  logic             div_ok;
  logic [WIDTH-1:0] rem_shift, rem_sub;
  logic [WIDTH-1:0] div_hi_n, div_lo_n;
  logic [WIDTH-1:0] hi_n, lo_n;
  logic             last_step;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? db_q : '0)};
    mul_hi_n  = mul_sum[WIDTH:1];
    mul_lo_n  = {mul_sum[0], lo_q[WIDTH-1:1]};

    rem_shift = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
    div_ok    = {hi_q, lo_q[WIDTH-1]} >= {1'b0, db_q};
    rem_sub   = rem_shift - db_q;
    div_hi_n  = div_ok ? rem_sub : rem_shift;
    div_lo_n  = {lo_q[WIDTH-2:0], div_ok};

    hi_n      = op_q[2] ? div_hi_n : mul_hi_n;
    lo_n      = op_q[2] ? div_lo_n : mul_lo_n;
    last_step = (cnt_q == LAST_CNT);
  end

  // ---------------------------------------------------------------------------
  // Sign correction and result selection on the final step
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [WIDTH-1:0]   calc_res;

  always_comb begin
    prod     = {hi_n, lo_n};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -lo_n : lo_n;
    rem_fix  = neg_q ? -hi_n : hi_n;
    case (op_q)
      3'b000:                 calc_res = prod_fix[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: calc_res = prod_fix[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         calc_res = quo_fix;
      default:                calc_res = rem_fix;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) state_d = special ? S_DONE : S_CALC;
        S_CALC: if (last_step) state_d = S_DONE;
        S_DONE: if (out_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers; flush freezes everything including the last result
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= OP_MUL;
      hi_q     <= '0;
      lo_q     <= '0;
      db_q     <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (!flush) begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_q  <= op;
            hi_q  <= '0;
            lo_q  <= mag_a;
            db_q  <= mag_b;
            neg_q <= neg_in;
            cnt_q <= '0;
            if (special) result_q <= special_res;
          end
        end
        S_CALC: begin
          hi_q  <= hi_n;
          lo_q  <= lo_n;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_step) result_q <= calc_res;
        end
        default: ;
      endcase
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: 32-bit and 8-bit instances checked against an
// arithmetic reference model, with latency, backpressure and abort scenarios.
module tb_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [2:0]  op;
  logic [31:0] a, b, result;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, result8;

  muldiv_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid8), .in_ready(in_ready8), .op(op8), .a(a8), .b(b8),
    .out_valid(out_valid8), .out_ready(out_ready8), .result(result8), .busy(busy8)
  );

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;

  exp_t        q32[$];
  exp_t        q8[$];
  bit          seen32 = 1'b0;
  bit          seen8 = 1'b0;
  logic [31:0] last32 = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: RISC-V M semantics computed with wide signed arithmetic.
  function automatic logic [63:0] model(input int w, input logic [2:0] o,
                                        input logic [63:0] x, input logic [63:0] y);
    logic [63:0]         mask;
    longint              xs, ys, q, r;
    logic signed [127:0] px, py, p, ph;
    mask = (64'd1 << w) - 64'd1;
    xs = x[w-1] ? longint'(x) - (longint'(1) << w) : longint'(x);
    ys = y[w-1] ? longint'(y) - (longint'(1) << w) : longint'(y);
    if (!o[2]) begin
      px = (o == MULH || o == MULHSU) ? 128'(xs) : 128'(x);
      py = (o == MULH) ? 128'(ys) : 128'(y);
      p  = px * py;
      ph = p >>> w;
      return (o == MUL) ? (p[63:0] & mask) : (ph[63:0] & mask);
    end
    if (y == 64'd0) return o[1] ? x : mask;
    if (!o[0]) begin
      if (x == (64'd1 << (w - 1)) && y == mask) return o[1] ? 64'd0 : x;
      q = xs / ys;
      r = xs % ys;
      return o[1] ? (64'(r) & mask) : (64'(q) & mask);
    end
    return o[1] ? (x % y) : (x / y);
  endfunction

  function automatic bit is_special(input int w, input logic [2:0] o,
                                    input logic [63:0] x, input logic [63:0] y);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    return o[2] && ((y == 64'd0) || (!o[0] && x == (64'd1 << (w - 1)) && y == mask));
  endfunction

  // Single compare process for both instances
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (q32.size() == 0) begin
        check("spurious_valid32", out_valid, 1'b0);
      end else begin
        if (!seen32) begin
          check("latency32", cyc, q32[0].due);
          seen32 = 1'b1;
        end
        check("result32", result, q32[0].res);
        check("in_ready_done32", in_ready, 1'b0);
        if (out_ready) begin
          last32 = q32[0].res;
          void'(q32.pop_front());
          seen32 = 1'b0;
        end
      end
    end
    if (out_valid8 === 1'b1) begin
      if (q8.size() == 0) begin
        check("spurious_valid8", out_valid8, 1'b0);
      end else begin
        if (!seen8) begin
          check("latency8", cyc, q8[0].due);
          seen8 = 1'b1;
        end
        check("result8", result8, q8[0].res);
        if (out_ready8) begin
          void'(q8.pop_front());
          seen8 = 1'b0;
        end
      end
    end
  end

  // Drivers are entered and left 1 time unit after a rising edge.
  task automatic issue32(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] lit);
    logic [63:0] m;
    int          k;
    m = model(32, o, 64'(x), 64'(y));
    check("model32", m, 64'(lit));
    k = 0;
    while (!in_ready && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("ready32", in_ready, 1'b1);
    op = o; a = x; b = y; in_valid = 1'b1;
    q32.push_back('{res: m[31:0], due: cyc + (is_special(32, o, 64'(x), 64'(y)) ? 1 : 33)});
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 3'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic wait32();
    int k;
    k = 0;
    while (q32.size() != 0 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("done32", q32.size(), 0);
  endtask

  task automatic run32(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] lit);
    issue32(o, x, y, lit);
    wait32();
  endtask

  task automatic run8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] lit);
    logic [63:0] m;
    int          k;
    m = model(8, o, 64'(x), 64'(y));
    check("model8", m, 64'(lit));
    check("ready8", in_ready8, 1'b1);
    op8 = o; a8 = x; b8 = y; in_valid8 = 1'b1;
    q8.push_back('{res: m[31:0], due: cyc + (is_special(8, o, 64'(x), 64'(y)) ? 1 : 9)});
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    k = 0;
    while (q8.size() != 0 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("done8", q8.size(), 0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1;
    in_valid8 = 1'b0; op8 = '0; a8 = '0; b8 = '0; out_ready8 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_result8", result8, 8'h0);

    // MUL with cycle-accurate busy profile
    issue32(MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    for (int k = 1; k <= 33; k++) begin
      check("busy_during_op", busy, 1'b1);
      @(posedge clk); #1;
    end
    check("busy_after_op", busy, 1'b0);
    check("in_ready_after_op", in_ready, 1'b1);
    wait32();

    run32(MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run32(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run32(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run32(MUL,    32'h1234_5678, 32'h9ABC_DEF0, 32'h242D_2080);
    run32(MULH,   32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF);
    run32(MULHU,  32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000);

    run32(DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    run32(REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    run32(DIVU, 32'd100,       32'd7,         32'd14);
    run32(REMU, 32'd100,       32'd7,         32'd2);
    run32(DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD);
    run32(REM,  32'd7,         32'hFFFF_FFFE, 32'd1);
    run32(DIVU, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF);
    run32(REM,  32'h8000_0000, 32'd3,         32'hFFFF_FFFE);

    run32(DIV,  32'd5,         32'd0,         32'hFFFF_FFFF);
    run32(REM,  32'd5,         32'd0,         32'd5);
    run32(DIVU, 32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF);
    run32(REMU, 32'h1234_5678, 32'd0,         32'h1234_5678);
    run32(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run32(REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0);

    // Backpressure: result held, in_valid pulses ignored
    out_ready = 1'b0;
    issue32(MULH, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF);
    for (int k = 0; k < 60 && !out_valid; k++) begin
      @(posedge clk); #1;
    end
    check("bp_valid_seen", out_valid, 1'b1);
    for (int k = 0; k < 10; k++) begin
      in_valid = k[0];
      op = MUL; a = $urandom; b = $urandom;
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_out_valid", out_valid, 1'b1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_handoff", q32.size(), 0);
    check("bp_ready_next", in_ready, 1'b1);
    check("bp_valid_drop", out_valid, 1'b0);
    run32(DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);

    // Flush in CALC cycle 10
    issue32(DIVU, 32'hFFFF_0000, 32'd3, 32'h5555_0000);
    repeat (9) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    q32.delete();
    seen32 = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", busy, 1'b0);
    check("flush_in_ready", in_ready, 1'b1);
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_result_held", result, last32);
    repeat (40) begin
      @(posedge clk); #1;
    end
    // flush wins over a same-cycle handshake
    flush = 1'b1; in_valid = 1'b1; op = DIVU; a = 32'd50; b = 32'd5;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_blocks_accept", busy, 1'b0);
    run32(DIVU, 32'd9, 32'd3, 32'd3);

    // Reset in CALC cycle 10
    issue32(DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2);
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    q32.delete();
    seen32 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst2_busy", busy, 1'b0);
    check("rst2_in_ready", in_ready, 1'b1);
    check("rst2_out_valid", out_valid, 1'b0);
    check("rst2_result", result, 32'h0);
    repeat (40) begin
      @(posedge clk); #1;
    end
    run32(REMU, 32'd100, 32'd7, 32'd2);

    // WIDTH=8 instance
    run8(MULHU, 8'hFF, 8'hFF, 8'hFE);
    run8(DIV,   8'h80, 8'hFF, 8'h80);
    run8(DIVU,  8'd200, 8'd7, 8'h1C);
    run8(REM,   8'hF9, 8'h02, 8'hFF);
    run8(MUL,   8'hFD, 8'h07, 8'hEB);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
